cache_set_assoc: RTL and testbench

//  Parametrised N-way set-associative tag/data store with true-LRU replacement and a line-fill FSM.

---
 rtl/cache_set_assoc.sv | 217 +++++++++++++++++++++
 tb/tb_cache_set_assoc.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/cache_set_assoc.sv
// cache_set_assoc
//   N-way set-associative tag/data store with true-LRU replacement and a
//   line-fill FSM. Requests are captured into a request register on one edge
//   and executed against the arrays on the next edge, where the registered
//   outputs are also produced.
// Ports
//   clk, rst (sync, active-low)
//   addr, din                      request address / write or fill data
//   lookup, edit, load, invalid    requests; priority invalid > load > edit > lookup
//   hit, hit_way, dout             lookup result (registered)
//   valid, dirty, tag, victim_way  state of the way the next fill would replace
//   filling                        fill FSM is in FILL
module cache_set_assoc #(
  parameter int ADDR_BITS  = 32,
  parameter int WORD_BITS  = 32,
  parameter int LINE_WORDS = 4,
  parameter int SET_NUM    = 64,
  parameter int WAYS       = 2,
  localparam int BOFF      = $clog2(WORD_BITS/8),
  localparam int WOFF      = $clog2(LINE_WORDS),
  localparam int OFF       = BOFF + WOFF,
  localparam int IDX       = $clog2(SET_NUM),
  localparam int TAG_BITS  = ADDR_BITS - IDX - OFF,
  localparam int WB        = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic                 lookup,
  input  logic                 edit,
  input  logic                 load,
  input  logic                 invalid,
  input  logic [WORD_BITS-1:0] din,
  output logic                 hit,
  output logic [WB-1:0]        hit_way,
  output logic [WORD_BITS-1:0] dout,
  output logic                 valid,
  output logic                 dirty,
  output logic [TAG_BITS-1:0]  tag,
  output logic [WB-1:0]        victim_way,
  output logic                 filling
);

  typedef enum logic {IDLE, FILL} state_t;

  state_t             state;
  logic [WOFF:0]      cnt;
  logic [IDX-1:0]     fset;
  logic [TAG_BITS-1:0] ftag;
  logic [WB-1:0]      fway;

  // request register
  logic                      q_lookup, q_edit, q_load, q_inv;
  logic [ADDR_BITS-1:BOFF]   q_addr;
  logic [WORD_BITS-1:0]      q_din;
  logic [TAG_BITS-1:0]       q_tag;
  logic [IDX-1:0]            q_set;
  logic [WOFF-1:0]           q_word;

  wire unused_byte_bits = &{1'b0, addr[BOFF-1:0]};

  assign q_tag  = q_addr[ADDR_BITS-1 -: TAG_BITS];
  assign q_set  = q_addr[OFF +: IDX];
  assign q_word = q_addr[OFF-1:BOFF];

  // storage; only valid/dirty/age carry reset
  logic [TAG_BITS-1:0]  tag_ram  [WAYS][SET_NUM];
  logic [WORD_BITS-1:0] data_ram [WAYS][SET_NUM][LINE_WORDS];
  logic [SET_NUM-1:0]   vld_bits [WAYS];
  logic [SET_NUM-1:0]   dty_bits [WAYS];
  // Age is stored XOR'd with the way index so the all-zero reset state
  // decodes to the ordering 0,1,..,WAYS-1, a legal LRU permutation.
  logic [WB-1:0]        age_q    [WAYS][SET_NUM];

  logic [WAYS-1:0]      way_hit;
  logic                 any_hit, busy_line, found_inv;
  logic [WB-1:0]        hit_idx, vic_idx, vic_inv, vic_age, lru_way, old_age;
  logic [WORD_BITS-1:0] hit_word;
  logic [WB-1:0]        eff_age [WAYS];
  logic [WB-1:0]        new_age [WAYS];
  logic                 do_inv, do_load, do_edit, do_look, any_req;

  assign do_inv  = q_inv;
  assign do_load = !q_inv && q_load;
  assign do_edit = !q_inv && !q_load && q_edit;
  assign do_look = !q_inv && !q_load && !q_edit && q_lookup;
  assign any_req = q_inv | q_load | q_edit | q_lookup;

  always_comb begin
    // the line under fill is never reported as a hit
    busy_line = (state == FILL) && (q_set == fset) && (q_tag == ftag);
    any_hit   = 1'b0;
    hit_idx   = '0;
    hit_word  = '0;
    found_inv = 1'b0;
    vic_inv   = '0;
    vic_age   = '0;
    for (int w = 0; w < WAYS; w++) begin
      way_hit[w] = vld_bits[w][q_set] && (tag_ram[w][q_set] == q_tag) && !busy_line;
      eff_age[w] = age_q[w][q_set] ^ WB'(w);
      if (way_hit[w]) begin
        any_hit  = 1'b1;
        hit_idx  = WB'(w);
        hit_word = data_ram[w][q_set][q_word];
      end
      if (!found_inv && !vld_bits[w][q_set]) begin
        found_inv = 1'b1;
        vic_inv   = WB'(w);
      end
      if (eff_age[w] == WB'(WAYS-1)) vic_age = WB'(w);
    end
    vic_idx = (WAYS == 1) ? '0 : (found_inv ? vic_inv : vic_age);

    // LRU: accessed way -> 0, ways younger than its old age age by one
    lru_way = do_load ? fway : hit_idx;
    old_age = eff_age[lru_way];
    for (int w = 0; w < WAYS; w++) begin
      if (WB'(w) == lru_way)        new_age[w] = WB'(w);
      else if (eff_age[w] < old_age) new_age[w] = (eff_age[w] + WB'(1)) ^ WB'(w);
      else                           new_age[w] = age_q[w][q_set];
    end
  end

  assign filling = (state == FILL);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_lookup   <= 1'b0;
      q_edit     <= 1'b0;
      q_load     <= 1'b0;
      q_inv      <= 1'b0;
      q_addr     <= '0;
      q_din      <= '0;
      state      <= IDLE;
      cnt        <= '0;
      fset       <= '0;
      ftag       <= '0;
      fway       <= '0;
      hit        <= 1'b0;
      hit_way    <= '0;
      dout       <= '0;
      valid      <= 1'b0;
      dirty      <= 1'b0;
      tag        <= '0;
      victim_way <= '0;
      for (int w = 0; w < WAYS; w++) begin
        vld_bits[w] <= '0;
        dty_bits[w] <= '0;
        for (int s = 0; s < SET_NUM; s++) age_q[w][s] <= '0;
      end
    end else begin
      q_lookup <= lookup;
      q_edit   <= edit;
      q_load   <= load;
      q_inv    <= invalid;
      q_addr   <= addr[ADDR_BITS-1:BOFF];
      q_din    <= din;

      if (any_req) begin
        hit        <= any_hit;
        hit_way    <= hit_idx;
        dout       <= hit_word;
        valid      <= vld_bits[vic_idx][q_set];
        dirty      <= dty_bits[vic_idx][q_set];
        tag        <= tag_ram[vic_idx][q_set];
        victim_way <= vic_idx;
      end

      if (do_inv) begin
        for (int w = 0; w < WAYS; w++)
          if (way_hit[w]) begin
            vld_bits[w][q_set] <= 1'b0;
            dty_bits[w][q_set] <= 1'b0;
          end
        if (state == FILL && q_set == fset) begin
          state <= IDLE;
          cnt   <= '0;
        end
      end else if (do_load) begin
        if (busy_line) begin
          data_ram[fway][fset][q_word] <= q_din;
          if (cnt == (WOFF+1)'(LINE_WORDS-1)) begin
            vld_bits[fway][fset] <= 1'b1;
            dty_bits[fway][fset] <= 1'b0;
            tag_ram[fway][fset]  <= ftag;
            if (WAYS > 1)
              for (int w = 0; w < WAYS; w++) age_q[w][fset] <= new_age[w];
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + (WOFF+1)'(1);
          end
        end else begin
          // new line (or a different line aborting the current fill)
          fset  <= q_set;
          ftag  <= q_tag;
          fway  <= vic_idx;
          data_ram[vic_idx][q_set][q_word] <= q_din;
          vld_bits[vic_idx][q_set] <= 1'b0;
          dty_bits[vic_idx][q_set] <= 1'b0;
          cnt   <= (WOFF+1)'(1);
          state <= FILL;
        end
      end else if (do_edit || do_look) begin
        if (any_hit) begin
          if (do_edit) begin
            data_ram[hit_idx][q_set][q_word] <= q_din;
            dty_bits[hit_idx][q_set]         <= 1'b1;
          end
          if (WAYS > 1)
            for (int w = 0; w < WAYS; w++) age_q[w][q_set] <= new_age[w];
        end
      end
    end
  end

endmodule

// File: tb/tb_cache_set_assoc.sv
// tb_cache_set_assoc
//   Directed bench for cache_set_assoc with WAYS=2, LINE_WORDS=4, SET_NUM=64
//   (tag=[31:10], set=[9:4], word=[3:2]). Each request is driven for one
//   cycle and its outputs are read one cycle after the sampling edge.
module tb_cache_set_assoc;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        lookup, edit, load, invalid;
  logic [31:0] din;
  logic        hit;
  logic [0:0]  hit_way;
  logic [31:0] dout;
  logic        valid, dirty;
  logic [21:0] tag;
  logic [0:0]  victim_way;
  logic        filling;

  int tests = 0;
  int fails = 0;

  cache_set_assoc dut (
    .clk(clk), .rst(rst), .addr(addr), .lookup(lookup), .edit(edit),
    .load(load), .invalid(invalid), .din(din), .hit(hit), .hit_way(hit_way),
    .dout(dout), .valid(valid), .dirty(dirty), .tag(tag),
    .victim_way(victim_way), .filling(filling)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  // drive one request for one cycle; return after its outputs are valid
  task automatic req(input logic lk, input logic ed, input logic ld,
                     input logic iv, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    lookup = lk; edit = ed; load = ld; invalid = iv; addr = a; din = d;
    @(negedge clk);
    lookup = 0; edit = 0; load = 0; invalid = 0;
    @(negedge clk);
  endtask

  task automatic rd(input logic [31:0] a);
    req(1, 0, 0, 0, a, 32'h0);
  endtask

  task automatic ld(input logic [31:0] a, input logic [31:0] d);
    req(0, 0, 1, 0, a, d);
  endtask

  initial begin
    rst = 0; addr = 0; din = 0;
    lookup = 0; edit = 0; load = 0; invalid = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("rst_hit", hit, 0);          chk("rst_hit_way", hit_way, 0);
    chk("rst_dout", dout, 0);        chk("rst_valid", valid, 0);
    chk("rst_dirty", dirty, 0);      chk("rst_tag", tag, 0);
    chk("rst_victim", victim_way, 0); chk("rst_filling", filling, 0);

    rd(32'h40);
    chk("cold_hit", hit, 0); chk("cold_valid", valid, 0); chk("cold_victim", victim_way, 0);

    // line A in set 4 -> way 0
    for (int i = 0; i < 4; i++) begin
      ld(32'h40 + 32'(4*i), 32'hA0 + 32'(i));
      if (i == 0) chk("fillA_busy", filling, 1);
    end
    chk("fillA_done", filling, 0);
    rd(32'h48);
    chk("A_hit", hit, 1); chk("A_way", hit_way, 0); chk("A_dout", dout, 32'hA2);

    // line B (tag 1) in set 4 -> way 1 (lowest invalid)
    for (int i = 0; i < 4; i++) begin
      ld(32'h440 + 32'(4*i), 32'hB0 + 32'(i));
      if (i == 0) begin chk("B_victim", victim_way, 1); chk("B_vvalid", valid, 0); end
    end
    rd(32'h44C);
    chk("B_hit", hit, 1); chk("B_way", hit_way, 1); chk("B_dout", dout, 32'hB3);
    rd(32'h40);  chk("A0_dout", dout, 32'hA0); chk("A0_way", hit_way, 0);
    rd(32'h440); chk("B0_dout", dout, 32'hB0); chk("B0_way", hit_way, 1);

    // line D (tag 2) replaces the LRU way 0
    for (int i = 0; i < 4; i++) begin
      ld(32'h840 + 32'(4*i), 32'hD0 + 32'(i));
      if (i == 0) begin
        chk("D_victim", victim_way, 0); chk("D_vvalid", valid, 1); chk("D_vtag", tag, 0);
      end
    end
    rd(32'h848); chk("D_hit", hit, 1); chk("D_way", hit_way, 0); chk("D_dout", dout, 32'hD2);
    rd(32'h40);  chk("A_gone", hit, 0);

    // write hit, then make way 1 the LRU again
    req(0, 1, 0, 0, 32'h444, 32'hDEAD);
    chk("edit_hit", hit, 1); chk("edit_way", hit_way, 1);
    rd(32'h444); chk("edit_dout", dout, 32'hDEAD);
    rd(32'h840); chk("D0_way", hit_way, 0);
    rd(32'hC40);
    chk("C_hit", hit, 0);     chk("C_vvalid", valid, 1); chk("C_vdirty", dirty, 1);
    chk("C_vtag", tag, 1);    chk("C_victim", victim_way, 1);

    // invalidate line D
    req(0, 0, 0, 1, 32'h844, 32'h0);
    rd(32'h840);
    chk("inv_hit", hit, 0); chk("inv_vvalid", valid, 0); chk("inv_victim", victim_way, 0);

    // set 6: line in way 0, then simultaneous load+edit: only the load runs
    for (int i = 0; i < 4; i++) ld(32'h60 + 32'(4*i), 32'hC0 + 32'(i));
    req(0, 1, 1, 0, 32'h64, 32'hEE);
    chk("prio_fill", filling, 1); chk("prio_hit", hit, 1);
    rd(32'h64);  chk("busy_miss", hit, 0);
    rd(32'h444); chk("other_set_hit", hit, 1); chk("other_set_dout", dout, 32'hDEAD);

    // set 7: two beats, then a different tag restarts the fill
    ld(32'h70, 32'hE0); chk("s7_busy", filling, 1);
    ld(32'h74, 32'hE1);
    ld(32'h470, 32'hF0);
    chk("restart_victim", victim_way, 0); chk("restart_vvalid", valid, 0);
    chk("restart_busy", filling, 1);
    ld(32'h474, 32'hF1); ld(32'h478, 32'hF2); ld(32'h47C, 32'hF3);
    chk("restart_done", filling, 0);
    rd(32'h64);  chk("prio_hit2", hit, 1); chk("prio_noedit", dout, 32'hC1);
    rd(32'h74);  chk("aborted_miss", hit, 0);
    rd(32'h478); chk("F_hit", hit, 1); chk("F_way", hit_way, 0); chk("F_dout", dout, 32'hF2);

    // reset in the middle of a fill
    ld(32'h80, 32'h10); ld(32'h84, 32'h11);
    chk("mid_busy", filling, 1);
    @(negedge clk); rst = 0;
    @(negedge clk); rst = 1;
    chk("mrst_filling", filling, 0); chk("mrst_hit", hit, 0);
    chk("mrst_hit_way", hit_way, 0); chk("mrst_dout", dout, 0);
    chk("mrst_valid", valid, 0);     chk("mrst_dirty", dirty, 0);
    chk("mrst_tag", tag, 0);         chk("mrst_victim", victim_way, 0);
    rd(32'h80);  chk("mrst_line_miss", hit, 0); chk("mrst_idle", filling, 0);
    rd(32'h478); chk("mrst_old_miss", hit, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
